// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// line levels and the clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Clocks per serial bit; callers guarantee an integer ratio of at least 2.
  function automatic int calc_div(input int clk_hz, input int sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side bundle of the buffered UART transmitter: write port, FIFO status
// and the serial line.
interface uart_tx_buffered_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_FIFO = 4
);
  logic                  we;
  logic [WIDTH-1:0]      data_tx;
  logic                  full;
  logic [DEPTH_FIFO:0]   level;
  logic                  busy;
  logic                  txd;

  modport master (output we, data_tx, input full, level, busy, txd);
  modport slave  (input we, data_tx, output full, level, busy, txd);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO: dout shows the head entry
// whenever empty is low, so a pop consumes the value already on dout.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_FIFO = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [WIDTH-1:0]    din,
  input  logic                re,
  output logic [WIDTH-1:0]    dout,
  output logic [DEPTH_FIFO:0] level,
  output logic                full,
  output logic                empty
);

  localparam int ENTRIES = 2 ** DEPTH_FIFO;

  logic [WIDTH-1:0]      mem [ENTRIES];
  logic [DEPTH_FIFO-1:0] wr_ptr;
  logic [DEPTH_FIFO-1:0] rd_ptr;
  logic [DEPTH_FIFO:0]   count;
  logic                  push;
  logic                  pop;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push  = we && !full;
  assign pop   = re && !empty;
  assign full  = (count == (DEPTH_FIFO + 1)'(ENTRIES));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are valid,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter: bytes written through the bus are
// queued and sent LSB first, back-to-back while the FIFO holds data.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int SCLK_HZ    = 5000000,
  parameter int WIDTH      = 8,
  parameter int DEPTH_FIFO = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_buffered_if.slave bus
);

  localparam int DIV    = calc_div(CLK_HZ, SCLK_HZ);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  tx_state_e             state, state_d;
  logic [TICK_W-1:0]     tick, tick_d;
  logic [BIT_W-1:0]      bit_cnt, bit_d;
  logic [WIDTH-1:0]      shift, shift_d;
  logic                  txd_q, txd_d;
  logic                  pop;
  logic [WIDTH-1:0]      fifo_dout;
  logic [DEPTH_FIFO:0]   fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;

  fifo_sync #(
    .WIDTH      (WIDTH),
    .DEPTH_FIFO (DEPTH_FIFO)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (bus.we),
    .din   (bus.data_tx),
    .re    (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd_q   <= IDLE_LEVEL;
    end else begin
      state   <= state_d;
      tick    <= tick_d;
      bit_cnt <= bit_d;
      shift   <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state;
    tick_d  = tick;
    bit_d   = bit_cnt;
    shift_d = shift;
    txd_d   = txd_q;
    pop     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        txd_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          tick_d  = '0;
          txd_d   = START_BIT;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (tick == TICK_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          txd_d   = shift[0];
          state_d = ST_DATA;
        end else begin
          tick_d = tick + TICK_W'(1);
        end
      end

      ST_DATA: begin
        if (tick == TICK_LAST) begin
          tick_d = '0;
          if (bit_cnt == BIT_LAST) begin
            txd_d   = STOP_BIT;
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift[WIDTH-1:1]};
            txd_d   = shift_d[0];
            bit_d   = bit_cnt + BIT_W'(1);
          end
        end else begin
          tick_d = tick + TICK_W'(1);
        end
      end

      ST_STOP: begin
        if (tick == TICK_LAST) begin
          tick_d = '0;
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            txd_d   = START_BIT;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick + TICK_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.txd   = txd_q;
  assign bus.full  = fifo_full;
  assign bus.level = fifo_level;
  assign bus.busy  = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a queue-and-waveform model checked every cycle,
// a bit-centre sampling receiver, and directed scenarios with literal values.
module tb_uart_tx_buffered;

  localparam int CLK_HZ     = 50000000;
  localparam int SCLK_HZ    = 5000000;
  localparam int WIDTH      = 8;
  localparam int DEPTH_FIFO = 4;
  localparam int DIV        = CLK_HZ / SCLK_HZ;
  localparam int ENTRIES    = 2 ** DEPTH_FIFO;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last_fall = 0;
  logic txd_prev = 1'b1;

  uart_tx_buffered_if #(.WIDTH(WIDTH), .DEPTH_FIFO(DEPTH_FIFO)) bus ();

  uart_tx_buffered #(
    .CLK_HZ     (CLK_HZ),
    .SCLK_HZ    (SCLK_HZ),
    .WIDTH      (WIDTH),
    .DEPTH_FIFO (DEPTH_FIFO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: buffered bytes plus the remaining txd samples of the frame on the line.
  logic [WIDTH-1:0] mq[$];
  logic             wave[$];
  logic             exp_txd = 1'b1;
  logic             active  = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    int               old_size;
    logic             do_push;
    logic [WIDTH-1:0] pushed;
    logic [WIDTH-1:0] b;
    if (!reset) begin
      mq.delete();
      wave.delete();
      active  = 1'b0;
      exp_txd = 1'b1;
    end else begin
      old_size = mq.size();
      do_push  = (bus.we === 1'b1) && (old_size < ENTRIES);
      pushed   = bus.data_tx;
      if (wave.size() == 0) begin
        if (old_size != 0) begin
          b = mq.pop_front();
          for (int i = 0; i < DIV; i++) wave.push_back(1'b0);
          for (int n = 0; n < WIDTH; n++)
            for (int i = 0; i < DIV; i++) wave.push_back(b[n]);
          for (int i = 0; i < DIV; i++) wave.push_back(1'b1);
          exp_txd = wave.pop_front();
          active  = 1'b1;
        end else begin
          active  = 1'b0;
          exp_txd = 1'b1;
        end
      end else begin
        exp_txd = wave.pop_front();
      end
      if (do_push) mq.push_back(pushed);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("txd",   {31'd0, bus.txd},  {31'd0, exp_txd});
      check("busy",  {31'd0, bus.busy}, {31'd0, (active || mq.size() != 0)});
      check("level", 32'(bus.level),    32'(mq.size()));
      check("full",  {31'd0, bus.full}, {31'd0, (mq.size() == ENTRIES)});
    end
    if (txd_prev && !bus.txd) last_fall = cyc;
    txd_prev = bus.txd;
  end

  // Loopback receiver sampling at bit centres.
  logic [WIDTH-1:0] rx_q[$];
  initial begin : receiver
    logic [WIDTH-1:0] r;
    forever begin
      @(negedge clk);
      if (reset && bus.txd == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        if (bus.txd == 1'b0) begin
          for (int i = 0; i < WIDTH; i++) begin
            repeat (DIV) @(negedge clk);
            r[i] = bus.txd;
          end
          repeat (DIV) @(negedge clk);
          if (bus.txd == 1'b1) rx_q.push_back(r);
        end
      end
    end
  end

  task automatic push_byte(input logic [WIDTH-1:0] b);
    bus.we      = 1'b1;
    bus.data_tx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_within_bound", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_rx(input string tag, input logic [WIDTH-1:0] first, input int n);
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_rx_byte"}, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxx_xxxx,
            32'(first + WIDTH'(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   t_fall;

  initial begin
    reset       = 1'b0;
    bus.we      = 1'b0;
    bus.data_tx = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle after reset.
    repeat (100) @(posedge clk);
    #1;
    check("idle_txd",   {31'd0, bus.txd},  32'd1);
    check("idle_busy",  {31'd0, bus.busy}, 32'd0);
    check("idle_full",  {31'd0, bus.full}, 32'd0);
    check("idle_level", 32'(bus.level),    32'd0);

    // Single 0x55: start bit one clock after the write, then bit-centre samples.
    rx_q.delete();
    push_byte(8'h55);
    bus.we = 1'b0;
    check("t2_txd_write_edge", {31'd0, bus.txd},  32'd1);
    check("t2_level_write",    32'(bus.level),    32'd1);
    check("t2_busy_write",     {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t2_txd_fall", {31'd0, bus.txd}, 32'd0);
    for (int n = 0; n < 10; n++) begin
      repeat ((n == 0) ? 5 : 10) @(posedge clk);
      #1;
      check("t2_bit_centre", {31'd0, bus.txd}, {31'd0, exp_bits[n]});
    end
    repeat (4) @(posedge clk);
    #1;
    check("t2_busy_before_end", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t2_busy_end", {31'd0, bus.busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check_rx("t2", 8'h55, 1);

    // Three contiguous frames.
    rx_q.delete();
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    bus.we = 1'b0;
    t_fall = last_fall;
    wait_idle(500);
    check("t3_total_clocks", 32'(cyc - t_fall), 32'd300);
    repeat (5) @(posedge clk);
    #1;
    check_rx("t3", 8'h41, 3);

    // Overflow: 20 writes, 17 make it through.
    rx_q.delete();
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    bus.we = 1'b0;
    check("t4_full",  {31'd0, bus.full}, 32'd1);
    check("t4_level", 32'(bus.level),    32'd16);
    wait_idle(2500);
    repeat (5) @(posedge clk);
    #1;
    check_rx("t4", 8'h00, 17);

    // Write while full on the same edge as the second pop.
    rx_q.delete();
    for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
    bus.we = 1'b0;
    repeat (84) @(posedge clk);
    #1;
    check("t5_full_before",  {31'd0, bus.full}, 32'd1);
    check("t5_level_before", 32'(bus.level),    32'd16);
    push_byte(8'hAA);
    bus.we = 1'b0;
    check("t5_level_after", 32'(bus.level),    32'd15);
    check("t5_full_after",  {31'd0, bus.full}, 32'd0);
    wait_idle(2500);
    repeat (5) @(posedge clk);
    #1;
    check_rx("t5", 8'h20, 17);

    // Reset in the middle of a 0xFF data phase, then a clean 0x0F.
    push_byte(8'hFF);
    push_byte(8'h77);
    bus.we = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t6_txd_reset",   {31'd0, bus.txd},  32'd1);
    check("t6_level_reset", 32'(bus.level),    32'd0);
    check("t6_busy_reset",  {31'd0, bus.busy}, 32'd0);
    check("t6_full_reset",  {31'd0, bus.full}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    rx_q.delete();
    push_byte(8'h0F);
    bus.we = 1'b0;
    wait_idle(500);
    repeat (5) @(posedge clk);
    #1;
    check_rx("t6", 8'h0F, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- FIFO-buffered UART transmitter: the transmit-side counterpart of the SoC's UART receive path (rxd/re/data_rx).
- CPU or bench pushes bytes through a write strobe; the block serialises them as 8N1 frames on txd.
- Drives the receiver's rxd in loopback benches; a debug-print sink for the mini16sc SoC.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz
- SCLK_HZ, 5000000, serial bit rate in Hz; DIV = CLK_HZ/SCLK_HZ clocks per bit (integer, DIV >= 2)
- WIDTH, 8, data bits per frame
- DEPTH_FIFO, 4, log2 of FIFO entries (default 16 entries)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- we  in  1  write strobe, one byte per cycle
- data_tx  in  WIDTH  byte to enqueue, sampled when we=1
- full  out  1  FIFO full; writes are dropped while high
- level  out  DEPTH_FIFO+1  current FIFO occupancy
- busy  out  1  frame in progress or FIFO non-empty
- txd  out  1  serial output, idle high

Behaviour:
- Reset (reset=0, async): txd=1, busy=0, full=0, level=0, FIFO pointers cleared, FSM=IDLE, bit/tick counters 0. A reset mid-frame truncates the frame immediately; txd returns high without waiting for a clock.
- Write: FIFO accepts on a rising edge when we=1 and full=0. A write while full=1 is silently dropped, even if a pop happens on the same edge; full is the registered value.
- full = (level == 2**DEPTH_FIFO); level is registered and updates on the edge after write/pop. A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, START, DATA, STOP. txd is registered.
- IDLE: txd=1. If level != 0 at an edge, pop the head into the shift register, set tick=0, txd<=0, and go to START.
- START: hold for DIV clocks. On the last tick, txd<=shift[0] and go to DATA with bit=0.
- DATA: each bit is held DIV clocks, LSB first. On each bit's last tick, shift right and increment bit. After bit WIDTH-1, txd<=1 and go to STOP.
- STOP: hold txd=1 for DIV clocks. On the last tick:
  - if level != 0, pop, txd<=0, and go to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
- Latency: a write on edge k into an empty FIFO with FSM in IDLE makes txd fall on edge k+1. The frame length is exactly (WIDTH+2)*DIV clocks.
- busy = (state != IDLE) || (level != 0), registered-equivalent. It rises on the edge after the first write and falls on the edge that enters IDLE with an empty FIFO.
- Tick counter width is clog2(DIV); bit counter width is clog2(WIDTH). Both wrap only under FSM control.
- FIFO pointers are DEPTH_FIFO bits and wrap naturally modulo 2**DEPTH_FIFO.

Decomposition:
- Shared package (uart_pkg):
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
  - DIV calculation helper function
  - constants for idle level (1), start bit (0), stop bit (1)
- One sub-module, fifo_sync: single-clock, async active-low reset, parameters WIDTH/DEPTH_FIFO, ports we/din/re/dout/level/full/empty. The FIFO must be first-word-fall-through, so dout is valid whenever empty=0.
- The FSM and shifter live in uart_tx_buffered.

Test Plan:
- Reset then idle 100 clocks -> txd=1, busy=0, full=0, level=0 throughout.
- Single write 0x55, DIV=10 -> txd low 1 clock after the write edge. Sampling at bit centres (+5 + 10n clocks) gives 0,1,0,1,0,1,0,1,0,1. busy falls 100 clocks after txd fell. The looped-back uart receiver asserts re with data_rx=0x55.
- Write 0x41,0x42,0x43 on consecutive clocks -> three contiguous frames, 300 clocks total, no idle gap between stop and start bits. The receiver yields 'A','B','C' in order.
- Write 20 bytes 0x00..0x13 back-to-back with DEPTH_FIFO=4:
  - the first byte is popped immediately, so 16 bytes are buffered;
  - full asserts, and the remaining 3 bytes are dropped;
  - received sequence is 0x00..0x10 (17 bytes).
- Write while full on the same edge as an internal pop -> the write is dropped and level decrements by 1.
- Assert reset for 1 clock mid-DATA of byte 0xFF -> txd=1 immediately and level=0. A new write of 0x0F then produces a clean, correctly framed 0x0F.
